// File: rtl/pb_serial_link.sv
// pb_serial_link: byte link between two PicoBlaze cores over a single-wire
// 8N1 serial line. The upstream core pushes bytes into a 4-entry transmit
// FIFO. A transmit FSM serialises them onto ser_tx. A receive FSM
// deserialises ser_rx into a holding register that the downstream core reads.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high
//   wr_port_id   : port_id of the writing PicoBlaze
//   wr_data      : out_port of the writing PicoBlaze
//   write_strobe : write qualifier
//   rd_port_id   : port_id of the reading PicoBlaze
//   read_strobe  : read qualifier
//   rd_data      : combinational read mux (RX byte / status / 0)
//   ser_tx       : registered serial output, idle high
//   ser_rx       : serial input, same clock domain
//
// TX and RX FSM states
//   state   | meaning
//   S_IDLE  | line idle; TX waits for FIFO data, RX waits for a low start edge
//   S_START | start bit; RX rechecks the line at the bit midpoint
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit; RX samples it at its midpoint

module pb_serial_link #(
   parameter logic [7:0] TX_PORT      = 8'h01,
   parameter logic [7:0] RX_PORT      = 8'h02,
   parameter logic [7:0] STAT_PORT    = 8'h03,
   parameter int         CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] wr_port_id,
   input  logic [7:0] wr_data,
   input  logic       write_strobe,
   input  logic [7:0] rd_port_id,
   input  logic       read_strobe,
   output logic [7:0] rd_data,
   output logic       ser_tx,
   input  logic       ser_rx
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   // transmit FIFO
   logic [7:0] fifo_mem_q [4];
   logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0] fifo_cnt_q, fifo_cnt_d;
   logic       fifo_empty, fifo_full;
   logic       push_req, push_ok, pop;

   // transmitter
   state_e        tx_state_q, tx_state_d;
   logic [CW-1:0] tx_tmr_q, tx_tmr_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          ser_tx_q, ser_tx_d;

   // receiver
   state_e        rx_state_q, rx_state_d;
   logic [CW-1:0] rx_tmr_q, rx_tmr_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_done, rx_ferr;

   // status flags
   logic rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
   logic frame_err_q, frame_err_d, tx_ovf_q, tx_ovf_d;
   logic rd_rx, rd_stat;

   assign fifo_empty = (fifo_cnt_q == 3'd0);
   assign fifo_full  = (fifo_cnt_q == 3'd4);
   assign push_req   = write_strobe && (wr_port_id == TX_PORT);
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign push_ok    = push_req && (!fifo_full || pop);
   assign rd_rx      = read_strobe && (rd_port_id == RX_PORT);
   assign rd_stat    = read_strobe && (rd_port_id == STAT_PORT);
   assign ser_tx     = ser_tx_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push_ok, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_tmr_d   = tx_tmr_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      ser_tx_d   = ser_tx_q;
      pop        = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            ser_tx_d = 1'b1;
            if (!fifo_empty) begin
               pop        = 1'b1;
               tx_shift_d = fifo_mem_q[rd_ptr_q];
               ser_tx_d   = 1'b0;
               tx_tmr_d   = BIT_LAST;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_tmr_q == '0) begin
               tx_tmr_d   = BIT_LAST;
               tx_bit_d   = 3'd0;
               ser_tx_d   = tx_shift_q[0];
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_state_d = S_DATA;
            end else begin
               tx_tmr_d = tx_tmr_q - 1'b1;
            end
         end
         S_DATA: begin
            if (tx_tmr_q == '0) begin
               tx_tmr_d = BIT_LAST;
               if (tx_bit_q == 3'd7) begin
                  ser_tx_d   = 1'b1;
                  tx_state_d = S_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  ser_tx_d   = tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end else begin
               tx_tmr_d = tx_tmr_q - 1'b1;
            end
         end
         S_STOP: begin
            if (tx_tmr_q == '0) begin
               // Chain straight into the next frame when data is waiting.
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  tx_shift_d = fifo_mem_q[rd_ptr_q];
                  ser_tx_d   = 1'b0;
                  tx_tmr_d   = BIT_LAST;
                  tx_state_d = S_START;
               end else begin
                  ser_tx_d   = 1'b1;
                  tx_state_d = S_IDLE;
               end
            end else begin
               tx_tmr_d = tx_tmr_q - 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_tmr_d   = rx_tmr_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      rx_ferr    = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (!ser_rx) begin
               rx_tmr_d   = HALF_LAST;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            if (rx_tmr_q == '0) begin
               if (ser_rx) begin
                  rx_state_d = S_IDLE;
               end else begin
                  rx_tmr_d   = BIT_LAST;
                  rx_bit_d   = 3'd0;
                  rx_state_d = S_DATA;
               end
            end else begin
               rx_tmr_d = rx_tmr_q - 1'b1;
            end
         end
         S_DATA: begin
            if (rx_tmr_q == '0) begin
               rx_tmr_d   = BIT_LAST;
               rx_shift_d = {ser_rx, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_tmr_d = rx_tmr_q - 1'b1;
            end
         end
         S_STOP: begin
            if (rx_tmr_q == '0) begin
               rx_done    = ser_rx;
               rx_ferr    = !ser_rx;
               rx_state_d = S_IDLE;
            end else begin
               rx_tmr_d = rx_tmr_q - 1'b1;
            end
         end
      endcase
   end

   // Clears are applied first so a same-cycle set overrides them.
   always_comb begin
      rx_data_d   = rx_done ? rx_shift_q : rx_data_q;
      rx_valid_d  = rx_valid_q;
      rx_ovr_d    = rx_ovr_q;
      frame_err_d = frame_err_q;
      tx_ovf_d    = tx_ovf_q;
      if (rd_rx) rx_valid_d = 1'b0;
      if (rd_stat) begin
         rx_ovr_d    = 1'b0;
         frame_err_d = 1'b0;
         tx_ovf_d    = 1'b0;
      end
      if (rx_done)                            rx_valid_d  = 1'b1;
      if (rx_done && rx_valid_q && !rd_rx)    rx_ovr_d    = 1'b1;
      if (rx_ferr)                            frame_err_d = 1'b1;
      if (push_req && !push_ok)               tx_ovf_d    = 1'b1;
   end

   always_comb begin
      rd_data = 8'h00;
      if (rd_port_id == RX_PORT) begin
         rd_data = rx_data_q;
      end else if (rd_port_id == STAT_PORT) begin
         rd_data = {1'b0, tx_ovf_q, frame_err_q, rx_ovr_q, rx_valid_q,
                    (tx_state_q != S_IDLE), fifo_full, fifo_empty};
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= 2'd0;
         rd_ptr_q    <= 2'd0;
         fifo_cnt_q  <= 3'd0;
         tx_state_q  <= S_IDLE;
         tx_tmr_q    <= '0;
         tx_bit_q    <= 3'd0;
         tx_shift_q  <= 8'h00;
         ser_tx_q    <= 1'b1;
         rx_state_q  <= S_IDLE;
         rx_tmr_q    <= '0;
         rx_bit_q    <= 3'd0;
         rx_shift_q  <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         rx_ovr_q    <= 1'b0;
         frame_err_q <= 1'b0;
         tx_ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         tx_state_q  <= tx_state_d;
         tx_tmr_q    <= tx_tmr_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         ser_tx_q    <= ser_tx_d;
         rx_state_q  <= rx_state_d;
         rx_tmr_q    <= rx_tmr_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_ovr_q    <= rx_ovr_d;
         frame_err_q <= frame_err_d;
         tx_ovf_q    <= tx_ovf_d;
      end
   end

endmodule

// File: doc/pb_serial_link.md
PB_SERIAL_LINK -- requirements
Module: pb_serial_link

Interface
REQ-001 Parameter TX_PORT, default 8'h01: port_id that pushes a byte into the transmit FIFO.
REQ-002 Parameter RX_PORT, default 8'h02: port_id that reads the received byte.
REQ-003 Parameter STAT_PORT, default 8'h03: port_id that reads the status byte.
REQ-004 Parameter CLKS_PER_BIT, default 16: clocks per serial bit; even, >= 4.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  reset is synchronous and active-high.
REQ-007 wr_port_id  input  8  port_id of the writing (upstream) PicoBlaze.
REQ-008 wr_data  input  8  out_port of the writing PicoBlaze.
REQ-009 write_strobe  input  1  write qualifier, one cycle per write.
REQ-010 rd_port_id  input  8  port_id of the reading (downstream) PicoBlaze.
REQ-011 read_strobe  input  1  read qualifier, one cycle per read.
REQ-012 rd_data  output  8  combinational read mux, to the reader's in_port.
REQ-013 ser_tx  output  1  registered serial output, idle high.
REQ-014 ser_rx  input  1  serial input, same clock domain, no synchronizer.

Function
REQ-015 Push: write_strobe=1 and wr_port_id==TX_PORT stores wr_data in a 4-entry FIFO at that edge; writes to other ports are ignored.
REQ-016 Push while FIFO full (4 entries, no pop that cycle) drops the byte and sets sticky tx_ovf; a push and pop in the same cycle on a full FIFO are both accepted.
REQ-017 Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-018 TX FSM states IDLE, START, DATA, STOP; IDLE with FIFO non-empty pops the head into the shift register and enters START at the same edge; ser_tx is 0 from that edge.
REQ-019 First-byte latency: byte pushed at edge N gives ser_tx=0 after edge N+1.
REQ-020 At the end of STOP, FIFO non-empty pops and enters START directly (no idle gap); otherwise returns to IDLE with ser_tx=1.
REQ-021 RX FSM states IDLE, START, DATA, STOP; IDLE with ser_rx=0 enters START; at CLKS_PER_BIT/2 cycles into START ser_rx is rechecked; 1 returns to IDLE (glitch rejected).
REQ-022 Data bits sampled every CLKS_PER_BIT cycles after the start midpoint; stop bit sampled at its midpoint, then RX returns to IDLE.
REQ-023 Stop sample 1: byte loaded into rx_data, rx_valid set; if rx_valid already 1 and not cleared that cycle, sticky rx_ovr set and rx_data overwritten.
REQ-024 Stop sample 0: sticky frame_err set, byte discarded, rx_valid unchanged.
REQ-025 rd_data: RX_PORT -> rx_data; STAT_PORT -> {0, tx_ovf, frame_err, rx_ovr, rx_valid, tx_busy, tx_full, tx_empty} (bit7..bit0); any other port -> 8'h00.
REQ-026 tx_busy = TX FSM not IDLE; tx_empty/tx_full reflect FIFO count 0/4.
REQ-027 read_strobe on RX_PORT clears rx_valid at that edge; read_strobe on STAT_PORT clears tx_ovf, frame_err, rx_ovr at that edge; rd_data shows pre-clear values.
REQ-028 Simultaneous set and clear of any flag: set wins (new byte arriving on an RX_PORT read leaves rx_valid=1, no rx_ovr).

Reset
REQ-029 Reset clears FIFO (empty), TX and RX FSMs to IDLE, ser_tx=1, rx_data=8'h00, all flags 0, bit counters 0; reset mid-frame aborts the frame at that edge.
REQ-030 Reset has priority over strobes in the same cycle.

Verification (CLKS_PER_BIT=16, ser_tx looped to ser_rx unless noted)
REQ-031 Write 8'hA5 to TX_PORT -> ser_tx low 16 cycles, then 1,0,1,0,0,1,0,1 (16 cycles each), stop high; rx_valid=1 ~152 cycles later; read RX_PORT returns 8'hA5, rx_valid clears next edge.
REQ-032 Writes of 8'h11..8'h16 on 6 consecutive cycles -> 8'h11..8'h15 sent back-to-back (800 cycles, no gap), 8'h16 dropped, status bit6=1; STAT_PORT read returns bit6=1 then bit6=0.
REQ-033 ser_rx driven low 4 cycles then high (no loopback) -> RX returns to IDLE, rx_valid and frame_err stay 0.
REQ-034 Injected frame with stop bit 0 -> frame_err=1, rx_valid=0, rx_data unchanged.
REQ-035 Two frames received without reading -> rx_ovr=1, rx_data=second byte; read RX_PORT in the completion cycle of a frame -> rx_valid stays 1, rx_ovr 0.
REQ-036 Reset asserted mid-DATA with 2 bytes queued -> ser_tx=1 after that edge, status reads 8'h01.
